plab2_proc_mem_arbiter: RTL and testbench

PLAB2_PROC_MEM_ARBITER -- requirements
Module: plab2_proc_MemArbiter

---
 rtl/plab2_proc_mem_arbiter_pkg.sv | 28 ++
 rtl/plab2_proc_mem_arbiter_tag_queue.sv | 70 +++++++
 rtl/plab2_proc_mem_arbiter.sv | 123 ++++++++++++
 tb/tb_plab2_proc_mem_arbiter.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/plab2_proc_mem_arbiter_pkg.sv
// Shared constants for the processor/memory arbiter: message widths,
// requester-id encodings and tag-queue sizing helpers.
package plab2_proc_mem_arbiter_pkg;

  // VC_MEM_REQ_MSG_NBITS(8,32,32): type(3) opaque(8) addr(32) len(2) data(32)
  localparam int unsigned MEM_REQ_NBITS  = 77;
  // VC_MEM_RESP_MSG_NBITS(8,32): type(3) opaque(8) len(2) data(32)
  localparam int unsigned MEM_RESP_NBITS = 45;

  localparam int unsigned NUM_OUT_NBITS        = 5;
  localparam int unsigned TAGQ_TAG_NBITS       = 1;
  localparam int unsigned TAGQ_MAX_DEPTH       = 16;
  localparam int unsigned TAGQ_DEFAULT_DEPTH   = 4;

  typedef enum logic {
    ARB_ID_IMEM = 1'b0,
    ARB_ID_DMEM = 1'b1
  } arb_id_e;

  function automatic int unsigned tagq_ptr_nbits(input int unsigned depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int unsigned tagq_cnt_nbits(input int unsigned depth);
    return tagq_ptr_nbits(depth) + 1;
  endfunction

endpackage

// File: rtl/plab2_proc_mem_arbiter_tag_queue.sv
// 1-bit-wide circular FIFO holding the requester id of every request
// still awaiting its memory response.
module plab2_proc_MemArbTagQueue
  import plab2_proc_mem_arbiter_pkg::*;
#(
  parameter int unsigned p_depth = TAGQ_DEFAULT_DEPTH
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               enq_val,
  input  logic                               enq_tag,
  input  logic                               deq_val,
  output logic                               deq_tag,
  output logic                               full,
  output logic                               empty,
  output logic [tagq_cnt_nbits(p_depth)-1:0] count
);

  localparam int unsigned PTR_W = tagq_ptr_nbits(p_depth);
  localparam int unsigned CNT_W = tagq_cnt_nbits(p_depth);

  logic [p_depth-1:0] tags_q, tags_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               push, pop;

  assign full    = (count_q == CNT_W'(p_depth));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign deq_tag = tags_q[rd_ptr_q];

  always_comb begin
    push     = enq_val && !full;
    pop      = deq_val && !empty;
    tags_d   = tags_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;

    if (push) begin
      tags_d[wr_ptr_q] = enq_tag;
      wr_ptr_d = (wr_ptr_q == PTR_W'(p_depth - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_W'(p_depth - 1)) ? '0 : rd_ptr_q + 1'b1;
    end

    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tags_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      tags_q   <= tags_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/plab2_proc_mem_arbiter.sv
// Two-requester (imem/dmem) memory arbiter with in-order response routing.
// Define PLAB2_PROC_MEM_ARBITER_ROUND_ROBIN_EN for round-robin; default is dmem-first.
module plab2_proc_mem_arbiter
  import plab2_proc_mem_arbiter_pkg::*;
#(
  parameter int unsigned p_max_outstanding = TAGQ_DEFAULT_DEPTH
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic [MEM_REQ_NBITS-1:0]  req0_msg,
  input  logic                      req0_val,
  output logic                      req0_rdy,

  input  logic [MEM_REQ_NBITS-1:0]  req1_msg,
  input  logic                      req1_val,
  output logic                      req1_rdy,

  output logic [MEM_REQ_NBITS-1:0]  memreq_msg,
  output logic                      memreq_val,
  input  logic                      memreq_rdy,

  input  logic [MEM_RESP_NBITS-1:0] memresp_msg,
  input  logic                      memresp_val,
  output logic                      memresp_rdy,

  output logic [MEM_RESP_NBITS-1:0] resp0_msg,
  output logic                      resp0_val,
  input  logic                      resp0_rdy,

  output logic [MEM_RESP_NBITS-1:0] resp1_msg,
  output logic                      resp1_val,
  input  logic                      resp1_rdy,

  output logic [NUM_OUT_NBITS-1:0]  num_outstanding
);

  localparam int unsigned CNT_W = tagq_cnt_nbits(p_max_outstanding);

  arb_id_e          sel;
  arb_id_e          head;
  logic             can_grant;
  logic             xfer;
  logic             have_tag;
  logic             deq_fire;
  logic             q_deq_tag;
  logic             q_full;
  logic             q_empty;
  logic [CNT_W-1:0] q_count;

`ifdef PLAB2_PROC_MEM_ARBITER_ROUND_ROBIN_EN
  arb_id_e last_q, last_d;
`endif

  // Grant selection; a lone valid always wins, ties resolved by policy.
  always_comb begin
    sel = ARB_ID_IMEM;
    if (req0_val && req1_val) begin
`ifdef PLAB2_PROC_MEM_ARBITER_ROUND_ROBIN_EN
      sel = (last_q == ARB_ID_DMEM) ? ARB_ID_IMEM : ARB_ID_DMEM;
`else
      sel = ARB_ID_DMEM;
`endif
    end else if (req1_val) begin
      sel = ARB_ID_DMEM;
    end
  end

  // Outputs are gated by reset so nothing handshakes while it is held low.
  always_comb begin
    can_grant  = reset && !q_full;
    memreq_val = can_grant && (req0_val || req1_val);
    memreq_msg = (sel == ARB_ID_DMEM) ? req1_msg : req0_msg;
    req0_rdy   = can_grant && memreq_rdy && req0_val && (sel == ARB_ID_IMEM);
    req1_rdy   = can_grant && memreq_rdy && req1_val && (sel == ARB_ID_DMEM);
    xfer       = memreq_val && memreq_rdy;
  end

  always_comb begin
    head        = arb_id_e'(q_deq_tag);
    have_tag    = reset && !q_empty;
    resp0_msg   = memresp_msg;
    resp1_msg   = memresp_msg;
    resp0_val   = have_tag && memresp_val && (head == ARB_ID_IMEM);
    resp1_val   = have_tag && memresp_val && (head == ARB_ID_DMEM);
    memresp_rdy = have_tag && ((head == ARB_ID_IMEM) ? resp0_rdy : resp1_rdy);
    deq_fire    = memresp_val && memresp_rdy;
  end

`ifdef PLAB2_PROC_MEM_ARBITER_ROUND_ROBIN_EN
  always_comb begin
    last_d = last_q;
    if (xfer) begin
      last_d = sel;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_q <= ARB_ID_DMEM;
    end else begin
      last_q <= last_d;
    end
  end
`endif

  plab2_proc_MemArbTagQueue #(
    .p_depth (p_max_outstanding)
  ) tag_queue (
    .clk     (clk),
    .rst_n   (reset),
    .enq_val (xfer),
    .enq_tag (sel),
    .deq_val (deq_fire),
    .deq_tag (q_deq_tag),
    .full    (q_full),
    .empty   (q_empty),
    .count   (q_count)
  );

  assign num_outstanding = NUM_OUT_NBITS'(q_count);

endmodule

// File: tb/tb_plab2_proc_mem_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic compared
// against a queue-based model of grant policy and in-order routing.
module tb_plab2_proc_mem_arbiter;
  import plab2_proc_mem_arbiter_pkg::*;

  localparam int unsigned MAXO = 4;

  logic                      clk;
  logic                      reset;
  logic [MEM_REQ_NBITS-1:0]  req0_msg, req1_msg, memreq_msg;
  logic                      req0_val, req0_rdy, req1_val, req1_rdy;
  logic                      memreq_val, memreq_rdy;
  logic [MEM_RESP_NBITS-1:0] memresp_msg, resp0_msg, resp1_msg;
  logic                      memresp_val, memresp_rdy;
  logic                      resp0_val, resp0_rdy, resp1_val, resp1_rdy;
  logic [NUM_OUT_NBITS-1:0]  num_outstanding;

  int unsigned checks = 0;
  int unsigned errors = 0;

  int unsigned tagq[$];
  int unsigned gnt_hist[$];
  int unsigned last_g = 1;
  int unsigned exp_g[4];

  plab2_proc_mem_arbiter #(.p_max_outstanding(MAXO)) dut (
    .clk             (clk),
    .reset           (reset),
    .req0_msg        (req0_msg),
    .req0_val        (req0_val),
    .req0_rdy        (req0_rdy),
    .req1_msg        (req1_msg),
    .req1_val        (req1_val),
    .req1_rdy        (req1_rdy),
    .memreq_msg      (memreq_msg),
    .memreq_val      (memreq_val),
    .memreq_rdy      (memreq_rdy),
    .memresp_msg     (memresp_msg),
    .memresp_val     (memresp_val),
    .memresp_rdy     (memresp_rdy),
    .resp0_msg       (resp0_msg),
    .resp0_val       (resp0_val),
    .resp0_rdy       (resp0_rdy),
    .resp1_msg       (resp1_msg),
    .resp1_val       (resp1_val),
    .resp1_rdy       (resp1_rdy),
    .num_outstanding (num_outstanding)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Arbitration rule: a lone requester wins; ties go by policy.
  function automatic int unsigned winner(input logic v0, input logic v1);
    if (v0 && v1) begin
`ifdef PLAB2_PROC_MEM_ARBITER_ROUND_ROBIN_EN
      return (last_g == 1) ? 0 : 1;
`else
      return 1;
`endif
    end
    return v1 ? 1 : 0;
  endfunction

  // Entered just after a negedge with inputs driven; leaves at the next negedge.
  task automatic cycle();
    int unsigned cnt, w, h;
    logic full, exp_mval, xfer, have, exp_mrdy, pop;
    cnt      = tagq.size();
    full     = (cnt == MAXO);
    w        = winner(req0_val, req1_val);
    exp_mval = (req0_val || req1_val) && !full;
    xfer     = exp_mval && memreq_rdy;
    have     = (cnt != 0);
    h        = have ? tagq[0] : 0;
    exp_mrdy = have && ((h == 0) ? resp0_rdy : resp1_rdy);
    pop      = memresp_val && exp_mrdy;
    #1;
    check("memreq_val", 128'(memreq_val), 128'(exp_mval));
    if (exp_mval) check("memreq_msg", 128'(memreq_msg), 128'((w == 1) ? req1_msg : req0_msg));
    check("req0_rdy", 128'(req0_rdy), 128'(xfer && w == 0));
    check("req1_rdy", 128'(req1_rdy), 128'(xfer && w == 1));
    check("memresp_rdy", 128'(memresp_rdy), 128'(exp_mrdy));
    check("resp0_val", 128'(resp0_val), 128'(have && memresp_val && h == 0));
    check("resp1_val", 128'(resp1_val), 128'(have && memresp_val && h == 1));
    check("resp0_msg", 128'(resp0_msg), 128'(memresp_msg));
    check("resp1_msg", 128'(resp1_msg), 128'(memresp_msg));
    check("num_outstanding", 128'(num_outstanding), 128'(cnt));
    if (req0_rdy || req1_rdy) gnt_hist.push_back(req1_rdy ? 1 : 0);
    @(posedge clk);
    if (pop) void'(tagq.pop_front());
    if (xfer) begin
      tagq.push_back(w);
      last_g = w;
    end
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    req0_val = 1'b0; req1_val = 1'b0; memreq_rdy = 1'b1;
    memresp_val = 1'b0; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
  endtask

  task automatic drain();
    idle_inputs();
    memresp_val = 1'b1;
    for (int i = 0; i < 20 && tagq.size() > 0; i++) cycle();
    check("drain_done", 128'(tagq.size()), 128'(0));
    memresp_val = 1'b0;
  endtask

  initial begin
    req0_msg = '0; req1_msg = '0; memresp_msg = '0;
    idle_inputs();
    reset = 1'b0;
    req0_val = 1'b1; req1_val = 1'b1; memresp_val = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    check("rst_memreq_val", 128'(memreq_val), 128'(0));
    check("rst_req0_rdy", 128'(req0_rdy), 128'(0));
    check("rst_req1_rdy", 128'(req1_rdy), 128'(0));
    check("rst_memresp_rdy", 128'(memresp_rdy), 128'(0));
    check("rst_resp_val", 128'({resp0_val, resp1_val}), 128'(0));
    check("rst_num_out", 128'(num_outstanding), 128'(0));
    @(negedge clk);
    reset = 1'b1;
    idle_inputs();

    // Tie-break sequence from a fresh reset
`ifdef PLAB2_PROC_MEM_ARBITER_ROUND_ROBIN_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
    exp_g[0] = 1; exp_g[1] = 1; exp_g[2] = 1; exp_g[3] = 1;
`endif
    gnt_hist.delete();
    req0_val = 1'b1; req1_val = 1'b1;
    req0_msg = MEM_REQ_NBITS'(77'h1111); req1_msg = MEM_REQ_NBITS'(77'h2222);
    repeat (4) cycle();
    check("tie_count", 128'(gnt_hist.size()), 128'(4));
    for (int i = 0; i < 4 && i < gnt_hist.size(); i++) check("tie_grant", 128'(gnt_hist[i]), 128'(exp_g[i]));
    drain();

    // imem-only request, response routed back to resp0
    req0_msg = {3'd0, 8'h00, 32'h0000_0100, 2'd0, 32'h0};
    req0_val = 1'b1;
    #1;
    check("imem_msg_pass", 128'(memreq_msg), 128'({3'd0, 8'h00, 32'h0000_0100, 2'd0, 32'h0}));
    cycle();
    req0_val = 1'b0;
    memresp_msg = {3'd0, 8'h00, 2'd0, 32'hDEAD_BEEF};
    memresp_val = 1'b1;
    #1;
    check("imem_resp0_val", 128'(resp0_val), 128'(1));
    check("imem_resp1_val", 128'(resp1_val), 128'(0));
    check("imem_resp_data", 128'(resp0_msg[31:0]), 128'(32'hDEAD_BEEF));
    cycle();
    memresp_val = 1'b0;

    // Queue full: fifth request stalls until a response has popped
    req0_val = 1'b1;
    repeat (4) cycle();
    #1;
    check("full_num_out", 128'(num_outstanding), 128'(MAXO));
    check("full_req0_rdy", 128'(req0_rdy), 128'(0));
    cycle();
    memresp_val = 1'b1;
    #1;
    check("full_pop_no_grant", 128'(req0_rdy), 128'(0));
    cycle();
    memresp_val = 1'b0;
    #1;
    check("full_grant_after", 128'(req0_rdy), 128'(1));
    cycle();
    drain();

    // In-order routing 0,1,1,0 with a back-pressured resp1
    for (int i = 0; i < 4; i++) begin
      req0_val = (i == 0 || i == 3);
      req1_val = (i == 1 || i == 2);
      cycle();
    end
    idle_inputs();
    memresp_val = 1'b1;
    #1;
    check("route_first_resp0", 128'(resp0_val), 128'(1));
    cycle();
    resp1_rdy = 1'b0;
    #1;
    check("route_stall_rdy", 128'(memresp_rdy), 128'(0));
    check("route_stall_val1", 128'(resp1_val), 128'(1));
    repeat (2) cycle();
    resp1_rdy = 1'b1;
    repeat (3) cycle();
    check("route_drained", 128'(tagq.size()), 128'(0));
    idle_inputs();

    // Reset with three outstanding, then a stray response
    req1_val = 1'b1;
    repeat (3) cycle();
    req1_val = 1'b0;
    reset = 1'b0;
    #1;
    check("mid_rst_num_out", 128'(num_outstanding), 128'(0));
    tagq.delete();
    last_g = 1;
    @(negedge clk);
    reset = 1'b1;
    memresp_val = 1'b1;
    #1;
    check("stray_memresp_rdy", 128'(memresp_rdy), 128'(0));
    check("stray_resp_val", 128'({resp0_val, resp1_val}), 128'(0));
    cycle();

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      req0_val    = ($urandom_range(0, 99) < 55);
      req1_val    = ($urandom_range(0, 99) < 55);
      memreq_rdy  = ($urandom_range(0, 99) < 75);
      memresp_val = ($urandom_range(0, 99) < 50);
      resp0_rdy   = ($urandom_range(0, 99) < 75);
      resp1_rdy   = ($urandom_range(0, 99) < 75);
      req0_msg    = MEM_REQ_NBITS'({$urandom(), $urandom(), $urandom()});
      req1_msg    = MEM_REQ_NBITS'({$urandom(), $urandom(), $urandom()});
      memresp_msg = MEM_RESP_NBITS'({$urandom(), $urandom()});
      cycle();
    end
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
